// File: rtl/koa_seq_mult.sv
// Sequential Karatsuba-Ofman multiplier: one (L+1)x(L+1) multiplier is time-shared
// across the three partial products, then a combine step forms the full 2*SW product.
module koa_seq_mult #(
    parameter int SW = 54
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [SW-1:0]   Data_A_i,
    input  logic [SW-1:0]   Data_B_i,
    input  logic            ack_i,
    output logic            ready_o,
    output logic            valid_o,
    output logic [2*SW-1:0] sgf_result_o
);

    localparam int H  = SW / 2;
    localparam int L  = SW - H;
    localparam int PW = 2 * L + 2;
    localparam int CW = 2 * SW + 2;
    localparam int RW = 2 * SW;

    typedef enum logic [2:0] {
        IDLE,
        MUL_L,
        MUL_R,
        MUL_M,
        COMB,
        DONE
    } state_t;

    state_t          state_q;
    logic [SW-1:0]   a_q, b_q;
    logic [PW-1:0]   ql_q, qr_q, qm_q;
    logic            valid_q;
    logic [RW-1:0]   result_q;
    logic [RW-1:0]   result_d;

    logic [H-1:0]    a_hi, b_hi;
    logic [L-1:0]    a_lo, b_lo;
    logic [L:0]      a_sum, b_sum;
    logic [L:0]      mul_a, mul_b;
    logic [PW-1:0]   mul_p;
    logic [CW-1:0]   ql_x, qr_x, qm_x;

    assign a_hi  = a_q[SW-1:L];
    assign a_lo  = a_q[L-1:0];
    assign b_hi  = b_q[SW-1:L];
    assign b_lo  = b_q[L-1:0];

    // Both sums carry one extra bit so the middle product never loses a carry.
    assign a_sum = {{(L+1-H){1'b0}}, a_hi} + {1'b0, a_lo};
    assign b_sum = {{(L+1-H){1'b0}}, b_hi} + {1'b0, b_lo};

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            MUL_L: begin
                mul_a = {{(L+1-H){1'b0}}, a_hi};
                mul_b = {{(L+1-H){1'b0}}, b_hi};
            end
            MUL_R: begin
                mul_a = {1'b0, a_lo};
                mul_b = {1'b0, b_lo};
            end
            MUL_M: begin
                mul_a = a_sum;
                mul_b = b_sum;
            end
            default: begin
            end
        endcase
    end

    assign mul_p = {{(L+1){1'b0}}, mul_a} * {{(L+1){1'b0}}, mul_b};

    // Combine in a width two bits wider than the product so no intermediate wraps.
    assign ql_x     = {{(CW-PW){1'b0}}, ql_q};
    assign qr_x     = {{(CW-PW){1'b0}}, qr_q};
    assign qm_x     = {{(CW-PW){1'b0}}, qm_q};
    assign result_d = RW'((ql_x << (2 * L)) + ((qm_x - ql_x - qr_x) << L) + qr_x);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            ql_q     <= '0;
            qr_q     <= '0;
            qm_q     <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        a_q     <= Data_A_i;
                        b_q     <= Data_B_i;
                        state_q <= MUL_L;
                    end
                end
                MUL_L: begin
                    ql_q    <= mul_p;
                    state_q <= MUL_R;
                end
                MUL_R: begin
                    qr_q    <= mul_p;
                    state_q <= MUL_M;
                end
                MUL_M: begin
                    qm_q    <= mul_p;
                    state_q <= COMB;
                end
                COMB: begin
                    result_q <= result_d;
                    valid_q  <= 1'b1;
                    state_q  <= DONE;
                end
                DONE: begin
                    if (ack_i) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_o      = (state_q == IDLE);
    assign valid_o      = valid_q;
    assign sgf_result_o = result_q;

endmodule

// File: tb/tb_koa_seq_mult.sv
// Bench for koa_seq_mult: directed scenarios plus randomized operands at SW=54 and SW=25,
// all checked against plain A*B arithmetic.
module tb_koa_seq_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic         start_54, ack_54, ready_54, valid_54;
  logic [53:0]  a_54, b_54;
  logic [107:0] res_54;

  logic         start_25, ack_25, ready_25, valid_25;
  logic [24:0]  a_25, b_25;
  logic [49:0]  res_25;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [107:0] exp_q[$];
  logic [49:0]  exp25_q[$];

  localparam logic [53:0] MAX54 = {54{1'b1}};
  localparam logic [24:0] MAX25 = {25{1'b1}};

  koa_seq_mult #(.SW(54)) u_dut54 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_54),
    .Data_A_i     (a_54),
    .Data_B_i     (b_54),
    .ack_i        (ack_54),
    .ready_o      (ready_54),
    .valid_o      (valid_54),
    .sgf_result_o (res_54)
  );

  koa_seq_mult #(.SW(25)) u_dut25 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_25),
    .Data_A_i     (a_25),
    .Data_B_i     (b_25),
    .ack_i        (ack_25),
    .ready_o      (ready_25),
    .valid_o      (valid_25),
    .sgf_result_o (res_25)
  );

  // Reference model: the full-width product by ordinary arithmetic.
  function automatic logic [107:0] ref_54(input logic [53:0] a, input logic [53:0] b);
    logic [107:0] p;
    p = {54'b0, a} * {54'b0, b};
    return p;
  endfunction

  function automatic logic [49:0] ref_25(input logic [24:0] a, input logic [24:0] b);
    logic [49:0] p;
    p = {25'b0, a} * {25'b0, b};
    return p;
  endfunction

  function automatic logic [53:0] rand_54();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[53:0];
  endfunction

  function automatic logic [24:0] rand_25();
    logic [31:0] r;
    r = $urandom();
    return r[24:0];
  endfunction

  // Driver: wait for ready, issue one request, then wait for valid.
  // lat counts rising edges from acceptance to valid (-1 on timeout). Leaves ack low.
  task automatic do_op_54(input logic [53:0] a, input logic [53:0] b,
                          output logic [107:0] res, output int lat);
    int w;
    w = 0;
    while (ready_54 !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    a_54 = a;
    b_54 = b;
    start_54 = 1'b1;
    @(negedge clk);
    start_54 = 1'b0;
    lat = -1;
    res = 'x;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (valid_54 === 1'b1) begin
        lat = i;
        res = res_54;
        break;
      end
    end
  endtask

  task automatic do_op_25(input logic [24:0] a, input logic [24:0] b,
                          output logic [49:0] res, output int lat);
    int w;
    w = 0;
    while (ready_25 !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    a_25 = a;
    b_25 = b;
    start_25 = 1'b1;
    @(negedge clk);
    start_25 = 1'b0;
    lat = -1;
    res = 'x;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (valid_25 === 1'b1) begin
        lat = i;
        res = res_25;
        break;
      end
    end
  endtask

  task automatic ack_pulse_54();
    ack_54 = 1'b1;
    @(negedge clk);
    ack_54 = 1'b0;
  endtask

  task automatic ack_pulse_25();
    ack_25 = 1'b1;
    @(negedge clk);
    ack_25 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_54 = 1'b0; ack_54 = 1'b0; a_54 = '0; b_54 = '0;
    start_25 = 1'b0; ack_25 = 1'b0; a_25 = '0; b_25 = '0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (ready_54 !== 1'b1) begin tests_failed++; $display("FAIL reset_ready54: got %b want 1", ready_54); end
    tests_run++;
    if (valid_54 !== 1'b0) begin tests_failed++; $display("FAIL reset_valid54: got %b want 0", valid_54); end
    tests_run++;
    if (res_54 !== 108'd0) begin tests_failed++; $display("FAIL reset_res54: got %h want 0", res_54); end
    tests_run++;
    if (ready_25 !== 1'b1) begin tests_failed++; $display("FAIL reset_ready25: got %b want 1", ready_25); end
    tests_run++;
    if (valid_25 !== 1'b0) begin tests_failed++; $display("FAIL reset_valid25: got %b want 0", valid_25); end
    tests_run++;
    if (res_25 !== 50'd0) begin tests_failed++; $display("FAIL reset_res25: got %h want 0", res_25); end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (ready_54 !== 1'b1) begin tests_failed++; $display("FAIL post_reset_ready54: got %b want 1", ready_54); end
  endtask

  task automatic test_all_ones();
    logic [107:0] res, pat, held;
    int lat;
    for (int i = 0; i < 108; i++) pat[i] = (i >= 55) || (i == 0);
    do_op_54(MAX54, MAX54, res, lat);
    tests_run++;
    if (lat !== 4) begin tests_failed++; $display("FAIL ones_latency: got %0d want 4", lat); end
    tests_run++;
    if (res !== ref_54(MAX54, MAX54)) begin tests_failed++; $display("FAIL ones_product: got %h want %h", res, ref_54(MAX54, MAX54)); end
    tests_run++;
    if (res !== pat) begin tests_failed++; $display("FAIL ones_bit_pattern: got %h want %h", res, pat); end
    tests_run++;
    if (ready_54 !== 1'b0) begin tests_failed++; $display("FAIL ones_ready_in_done: got %b want 0", ready_54); end
    held = res;
    ack_pulse_54();
    tests_run++;
    if (valid_54 !== 1'b0) begin tests_failed++; $display("FAIL ones_valid_after_ack: got %b want 0", valid_54); end
    tests_run++;
    if (ready_54 !== 1'b1) begin tests_failed++; $display("FAIL ones_ready_after_ack: got %b want 1", ready_54); end
    tests_run++;
    if (res_54 !== held) begin tests_failed++; $display("FAIL ones_result_held_after_ack: got %h want %h", res_54, held); end
  endtask

  task automatic test_small();
    logic [107:0] res;
    int lat;
    do_op_54(54'd3, 54'd5, res, lat);
    tests_run++;
    if (res !== 108'd15) begin tests_failed++; $display("FAIL small_3x5: got %0d want 15", res); end
    tests_run++;
    if (lat !== 4) begin tests_failed++; $display("FAIL small_latency: got %0d want 4", lat); end
    ack_pulse_54();
    do_op_54(54'd0, MAX54, res, lat);
    tests_run++;
    if (valid_54 !== 1'b1) begin tests_failed++; $display("FAIL zero_valid: got %b want 1", valid_54); end
    tests_run++;
    if (res !== 108'd0) begin tests_failed++; $display("FAIL zero_product: got %h want 0", res); end
    ack_pulse_54();
  endtask

  task automatic test_hold();
    logic [107:0] res, e;
    logic [53:0] a, b;
    int lat;
    a = rand_54() | 54'd1;
    b = rand_54() | 54'd1;
    e = ref_54(a, b);
    do_op_54(a, b, res, lat);
    tests_run++;
    if (res !== e) begin tests_failed++; $display("FAIL hold_product: got %h want %h", res, e); end
    for (int i = 0; i < 10; i++) begin
      start_54 = 1'b1;
      a_54 = rand_54();
      b_54 = rand_54();
      @(negedge clk);
      tests_run++;
      if (valid_54 !== 1'b1) begin tests_failed++; $display("FAIL hold_valid cycle %0d: got %b want 1", i, valid_54); end
      tests_run++;
      if (res_54 !== e) begin tests_failed++; $display("FAIL hold_result cycle %0d: got %h want %h", i, res_54, e); end
      tests_run++;
      if (ready_54 !== 1'b0) begin tests_failed++; $display("FAIL hold_ready cycle %0d: got %b want 0", i, ready_54); end
    end
    // ack together with start: the ack wins, the start is dropped.
    ack_54 = 1'b1;
    @(negedge clk);
    ack_54 = 1'b0;
    start_54 = 1'b0;
    tests_run++;
    if (ready_54 !== 1'b1) begin tests_failed++; $display("FAIL ack_start_ready: got %b want 1", ready_54); end
    tests_run++;
    if (valid_54 !== 1'b0) begin tests_failed++; $display("FAIL ack_start_valid: got %b want 0", valid_54); end
    tests_run++;
    if (res_54 !== e) begin tests_failed++; $display("FAIL ack_start_result_held: got %h want %h", res_54, e); end
  endtask

  task automatic test_reset_mid();
    logic [107:0] res, e;
    logic [53:0] a, b;
    int lat;
    bit seen_valid;
    a_54 = rand_54() | 54'd1;
    b_54 = rand_54() | 54'd1;
    start_54 = 1'b1;
    @(negedge clk);
    start_54 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (valid_54 !== 1'b0) begin tests_failed++; $display("FAIL midreset_valid: got %b want 0", valid_54); end
    tests_run++;
    if (res_54 !== 108'd0) begin tests_failed++; $display("FAIL midreset_result: got %h want 0", res_54); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (ready_54 !== 1'b1) begin tests_failed++; $display("FAIL midreset_ready_after_release: got %b want 1", ready_54); end
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (valid_54 !== 1'b0) seen_valid = 1'b1;
    end
    tests_run++;
    if (seen_valid !== 1'b0) begin tests_failed++; $display("FAIL midreset_spurious_valid: got %b want 0", seen_valid); end
    a = rand_54();
    b = rand_54();
    e = ref_54(a, b);
    do_op_54(a, b, res, lat);
    tests_run++;
    if (res !== e) begin tests_failed++; $display("FAIL midreset_recovery: got %h want %h", res, e); end
    ack_pulse_54();
  endtask

  task automatic test_back_to_back();
    logic [107:0] e;
    int cyc, last_valid, results;
    exp_q.delete();
    ack_54 = 1'b1;
    start_54 = 1'b1;
    last_valid = -1;
    results = 0;
    for (cyc = 0; cyc < 70; cyc++) begin
      if (valid_54 === 1'b1) begin
        results++;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL b2b_unexpected_result: got %h want none", res_54);
        end else begin
          e = exp_q.pop_front();
          if (res_54 !== e) begin tests_failed++; $display("FAIL b2b_result: got %h want %h", res_54, e); end
        end
        if (last_valid >= 0) begin
          tests_run++;
          if (cyc - last_valid !== 6) begin tests_failed++; $display("FAIL b2b_interval: got %0d want 6", cyc - last_valid); end
        end
        last_valid = cyc;
      end
      if (cyc >= 60) start_54 = 1'b0;
      a_54 = rand_54();
      b_54 = rand_54();
      if (ready_54 === 1'b1 && start_54 === 1'b1) exp_q.push_back(ref_54(a_54, b_54));
      @(negedge clk);
    end
    ack_54 = 1'b0;
    tests_run++;
    if (results < 9) begin tests_failed++; $display("FAIL b2b_result_count: got %0d want >= 9", results); end
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL b2b_leftover: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_random_54(input int n);
    logic [107:0] res, e;
    logic [53:0] a, b;
    int lat, sel;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      sel = $urandom_range(0, 15);
      a = (sel == 0) ? MAX54 : (sel == 1) ? 54'd0 : rand_54();
      b = (sel == 2) ? MAX54 : (sel == 3) ? 54'd0 : rand_54();
      exp_q.push_back(ref_54(a, b));
      do_op_54(a, b, res, lat);
      e = exp_q.pop_front();
      tests_run++;
      if (res !== e) begin tests_failed++; $display("FAIL rand54_product a=%h b=%h: got %h want %h", a, b, res, e); end
      tests_run++;
      if (lat !== 4) begin tests_failed++; $display("FAIL rand54_latency: got %0d want 4", lat); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ack_pulse_54();
    end
  endtask

  task automatic test_random_25(input int n);
    logic [49:0] res, e;
    logic [24:0] a, b;
    int lat, sel;
    exp25_q.delete();
    for (int i = 0; i < n; i++) begin
      sel = $urandom_range(0, 15);
      a = (sel == 0) ? MAX25 : (sel == 1) ? 25'd0 : rand_25();
      b = (sel == 2) ? MAX25 : (sel == 3) ? 25'd0 : rand_25();
      exp25_q.push_back(ref_25(a, b));
      do_op_25(a, b, res, lat);
      e = exp25_q.pop_front();
      tests_run++;
      if (res !== e) begin tests_failed++; $display("FAIL rand25_product a=%h b=%h: got %h want %h", a, b, res, e); end
      tests_run++;
      if (lat !== 4) begin tests_failed++; $display("FAIL rand25_latency: got %0d want 4", lat); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ack_pulse_25();
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_small();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_random_54(2500);
    test_random_25(2500);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1);
  end

endmodule
